// File: rtl/mca_rr_scheduler.sv
// ---------------------------------------------------------------------------
// mca_rr_scheduler
//   Shares one pipelined Fp-width adder between N_REQ requesters using
//   round-robin arbitration. At most one addition is issued per cycle. A tag
//   pipeline aligned to the adder carries each operation's requester ID, so
//   every sum returns with the ID of the requester that issued it.
//
//   multi_cycle_adder : free-running adder, Z = X + Y after LATENCY clocks.
//
// Ports (mca_rr_scheduler):
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   req_valid  in   [N_REQ]        per-requester operation request
//   req_ready  out  [N_REQ]        one-hot (or zero) grant
//   req_X      in   [N_REQ][FP_W]  operand X per requester
//   req_Y      in   [N_REQ][FP_W]  operand Y per requester
//   issue_en   in   when low, no grant is given
//   res_valid  out  one-cycle strobe per accepted request
//   res_id     out  [ID_W] requester index of the current result
//   res_Z      out  [FP_W] (X + Y) mod 2^FP_W, don't-care while res_valid=0
//   busy       out  operation present in the issue register or tag pipeline
//   n_issued   out  [32] accepted-request count, wraps at 2^32
// ---------------------------------------------------------------------------

module multi_cycle_adder #(
    parameter int WIDTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Z
);

    logic [WIDTH-1:0] pipe_q [LATENCY];

    // NOTE: pure datapath registers carry no reset; validity travels with the
    // tags, so resetting wide data would only cost routing and reset fanout.
    always_ff @(posedge clk) begin
        pipe_q[0] <= X + Y;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign Z = pipe_q[LATENCY-1];

endmodule

module mca_rr_scheduler #(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 2,
    parameter int ID_W    = $clog2(N_REQ),
    parameter int FP_W    = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ-1:0][FP_W-1:0] req_X,
    input  logic [N_REQ-1:0][FP_W-1:0] req_Y,
    input  logic                       issue_en,
    output logic                       res_valid,
    output logic [ID_W-1:0]            res_id,
    output logic [FP_W-1:0]            res_Z,
    output logic                       busy,
    output logic [31:0]                n_issued
);

    logic [ID_W-1:0] last_q, last_d;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic            accept;
    logic [31:0]     n_issued_q, n_issued_d;

    logic [FP_W-1:0] x_r_q, y_r_q;
    logic [FP_W-1:0] sum_z;
    logic [FP_W-1:0] res_z_q;

    // Stage 0 is the issue register (v0/id0); stages 1..LATENCY follow the adder.
    logic [LATENCY:0] tag_v_q;
    logic [ID_W-1:0]  tag_id_q [LATENCY+1];
    logic             res_valid_q;
    logic [ID_W-1:0]  res_id_q;

    // Round-robin search starting just after the last granted requester.
    // NOTE: every variable assigned in always_comb gets a default first, so a
    // path that skips an assignment can never infer a latch.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(last_q) + k) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Grant only goes out when a requester is actually asking, so a granted
    // requester is accepted by construction.
    assign accept = grant_found & issue_en & ~rst;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign last_d     = accept ? grant_idx : last_q;
    assign n_issued_d = n_issued_q + 32'(accept);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q      <= ID_W'(N_REQ - 1);
            n_issued_q  <= '0;
            tag_v_q     <= '0;
            for (int i = 0; i <= LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
        end else begin
            last_q      <= last_d;
            n_issued_q  <= n_issued_d;
            tag_v_q     <= {tag_v_q[LATENCY-1:0], accept};
            tag_id_q[0] <= grant_idx;
            for (int i = 1; i <= LATENCY; i++) begin
                tag_id_q[i] <= tag_id_q[i-1];
            end
            res_valid_q <= tag_v_q[LATENCY];
            res_id_q    <= tag_id_q[LATENCY];
        end
    end

    // Operand and result data registers; operands hold when nothing is issued.
    always_ff @(posedge clk) begin
        if (accept) begin
            x_r_q <= req_X[grant_idx];
            y_r_q <= req_Y[grant_idx];
        end
        res_z_q <= sum_z;
    end

    multi_cycle_adder #(
        .WIDTH   (FP_W),
        .LATENCY (LATENCY)
    ) u_adder (
        .clk (clk),
        .X   (x_r_q),
        .Y   (y_r_q),
        .Z   (sum_z)
    );

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_Z     = res_z_q;
    assign busy      = |tag_v_q;
    assign n_issued  = n_issued_q;

endmodule

// File: tb/tb_mca_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mca_rr_scheduler
//   Drives mca_rr_scheduler (N_REQ=4, LATENCY=2, 256-bit operands) from a
//   round-robin reference model. Expected sums with their IDs and due cycles
//   are queued at grant time and compared by a negedge monitor.
// ---------------------------------------------------------------------------

module tb_mca_rr_scheduler;

    localparam int N = 4;
    localparam int L = 2;
    localparam int W = 256;
    localparam int IW = 2;

    typedef struct {
        logic [IW-1:0] id;
        logic [W-1:0]  z;
        int            due;
    } exp_t;

    logic                  clk;
    logic                  rst;
    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_ready;
    logic [N-1:0][W-1:0]   req_X;
    logic [N-1:0][W-1:0]   req_Y;
    logic                  issue_en;
    logic                  res_valid;
    logic [IW-1:0]         res_id;
    logic [W-1:0]          res_Z;
    logic                  busy;
    logic [31:0]           n_issued;

    mca_rr_scheduler #(
        .N_REQ   (N),
        .LATENCY (L),
        .FP_W    (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_X     (req_X),
        .req_Y     (req_Y),
        .issue_en  (issue_en),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_Z     (res_Z),
        .busy      (busy),
        .n_issued  (n_issued)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Bench counters and reference model state.
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb[$];
    int          m_ptr = N - 1;
    logic [31:0] m_issued = '0;
    int          m_last_acc = -100;
    logic [W-1:0] nx [N];
    logic [W-1:0] ny [N];

    int           gd;
    logic [N-1:0] od;

    function automatic logic [W-1:0] rnd_fp();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W / 32; i++) r = {r[W-33:0], 32'($urandom())};
        return r;
    endfunction

    // Result monitor: checks res_valid every cycle and id/sum on strobes.
    always @(negedge clk) begin
        logic exp_v;
        exp_t e;
        if (sb.size() > 0 && sb[0].due < cyc) begin
            n_cmp++; n_bad++;
            $display("FAIL late_result: id %0d due cycle %0d not seen by cycle %0d",
                     sb[0].id, sb[0].due, cyc);
            void'(sb.pop_front());
        end
        exp_v = (sb.size() > 0) && (sb[0].due == cyc);
        n_cmp++;
        if (res_valid !== exp_v) begin
            n_bad++;
            $display("FAIL res_valid: cycle %0d got %b want %b", cyc, res_valid, exp_v);
        end else if (exp_v) begin
            e = sb.pop_front();
            n_cmp++;
            if (res_id !== e.id) begin
                n_bad++;
                $display("FAIL res_id: cycle %0d got %0d want %0d", cyc, res_id, e.id);
            end
            n_cmp++;
            if (res_Z !== e.z) begin
                n_bad++;
                $display("FAIL res_Z: cycle %0d id %0d got %h want %h", cyc, e.id, res_Z, e.z);
            end
        end
    end

    // One cycle: apply inputs at negedge, check grant/busy/n_issued against
    // the model, and queue the expected result of any grant.
    task automatic drive_cycle(input logic [N-1:0] v, input logic en, input logic r,
                               output int g, output logic [N-1:0] obs);
        logic [N-1:0] exp_rdy;
        logic         exp_busy;
        exp_t         e;
        @(negedge clk);
        rst       = r;
        req_valid = v;
        issue_en  = en;
        for (int i = 0; i < N; i++) begin
            req_X[i] = nx[i];
            req_Y[i] = ny[i];
        end
        #1;
        if (r) begin
            sb.delete();
            m_ptr      = N - 1;
            m_issued   = '0;
            m_last_acc = -100;
        end
        g = -1;
        if (en && !r) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        obs = req_ready;
        n_cmp++;
        if (req_ready !== exp_rdy) begin
            n_bad++;
            $display("FAIL req_ready: cycle %0d got %b want %b", cyc, req_ready, exp_rdy);
        end
        exp_busy = (cyc - m_last_acc >= 0) && (cyc - m_last_acc <= L);
        n_cmp++;
        if (busy !== exp_busy) begin
            n_bad++;
            $display("FAIL busy: cycle %0d got %b want %b", cyc, busy, exp_busy);
        end
        n_cmp++;
        if (n_issued !== m_issued) begin
            n_bad++;
            $display("FAIL n_issued: cycle %0d got %0d want %0d", cyc, n_issued, m_issued);
        end
        if (g >= 0) begin
            e.id  = IW'(g);
            e.z   = nx[g] + ny[g];
            e.due = cyc + L + 2;
            sb.push_back(e);
            m_ptr      = g;
            m_issued   = m_issued + 1;
            m_last_acc = cyc + 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle('0, 1'b1, 1'b0, gd, od);
    endtask

    task automatic test_reset;
        drive_cycle('1, 1'b1, 1'b1, gd, od);
        drive_cycle('1, 1'b1, 1'b1, gd, od);
        n_cmp++;
        if (res_valid !== 1'b0 || res_id !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: res_valid %b res_id %0d want 0/0", res_valid, res_id);
        end
        idle(1);
    endtask

    task automatic test_single;
        nx[2] = W'(5);
        ny[2] = W'(7);
        drive_cycle(4'b0100, 1'b1, 1'b0, gd, od);
        n_cmp++;
        if (od !== 4'b0100) begin
            n_bad++;
            $display("FAIL single_grant: got %b want 0100", od);
        end
        idle(L + 4);
        n_cmp++;
        if (n_issued !== 32'd1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_after: n_issued %0d busy %b want 1/0", n_issued, busy);
        end
    endtask

    task automatic test_contention;
        drive_cycle('1, 1'b1, 1'b1, gd, od);
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < N; i++) begin
                nx[i] = rnd_fp();
                ny[i] = rnd_fp();
            end
            drive_cycle('1, 1'b1, 1'b0, gd, od);
            n_cmp++;
            if (od !== 4'(1 << (k % N))) begin
                n_bad++;
                $display("FAIL contention_order: step %0d got %b want %b", k, od, 4'(1 << (k % N)));
            end
        end
        idle(L + 3);
    endtask

    task automatic test_round_robin;
        int wait_n;
        drive_cycle(4'b1000, 1'b1, 1'b0, gd, od);
        for (int k = 0; k < 4; k++) begin
            drive_cycle(4'b1010, 1'b1, 1'b0, gd, od);
            n_cmp++;
            if (od !== ((k % 2 == 0) ? 4'b0010 : 4'b1000)) begin
                n_bad++;
                $display("FAIL rr_alternate: step %0d got %b", k, od);
            end
        end
        wait_n = 0;
        for (int k = 0; k < 4; k++) begin
            drive_cycle(4'b1011, 1'b1, 1'b0, gd, od);
            if (wait_n == 0 && od[0]) wait_n = k + 1;
        end
        n_cmp++;
        if (wait_n < 1 || wait_n > 2) begin
            n_bad++;
            $display("FAIL rr_fairness: requester 0 granted at grant %0d want 1..2", wait_n);
        end
        idle(L + 3);
    endtask

    task automatic test_hold;
        drive_cycle('1, 1'b1, 1'b1, gd, od);
        drive_cycle('1, 1'b1, 1'b0, gd, od);
        drive_cycle('1, 1'b1, 1'b0, gd, od);
        for (int k = 0; k < 5; k++) drive_cycle('1, 1'b0, 1'b0, gd, od);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_busy: got %b want 0", busy);
        end
        drive_cycle('1, 1'b1, 1'b0, gd, od);
        n_cmp++;
        if (od !== 4'b0100) begin
            n_bad++;
            $display("FAIL hold_resume: got %b want 0100", od);
        end
        idle(L + 3);
    endtask

    task automatic test_wrap;
        int acc;
        nx[1] = '1;
        ny[1] = W'(1);
        drive_cycle(4'b0010, 1'b1, 1'b0, gd, od);
        nx[1] = {1'b1, {(W-1){1'b0}}};
        ny[1] = {1'b1, {(W-1){1'b0}}};
        drive_cycle(4'b0010, 1'b1, 1'b0, gd, od);
        idle(L + 3);
        acc = 0;
        for (int c = 0; c < 20000 && acc < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                nx[i] = ($urandom_range(0, 15) == 0) ? '1 : rnd_fp();
                ny[i] = rnd_fp();
            end
            drive_cycle(4'($urandom_range(1, 15)), ($urandom_range(0, 7) != 0), 1'b0, gd, od);
            if (gd >= 0) acc++;
        end
        n_cmp++;
        if (acc < 10000) begin
            n_bad++;
            $display("FAIL random_budget: accepted %0d want 10000", acc);
        end
        idle(L + 3);
    endtask

    task automatic test_reset_midflight;
        drive_cycle(4'b0001, 1'b1, 1'b0, gd, od);
        drive_cycle(4'b0010, 1'b1, 1'b0, gd, od);
        drive_cycle('0, 1'b1, 1'b0, gd, od);
        drive_cycle(4'b1111, 1'b1, 1'b1, gd, od);
        drive_cycle(4'b1111, 1'b1, 1'b1, gd, od);
        n_cmp++;
        if (n_issued !== 32'd0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midflight_reset: n_issued %0d busy %b want 0/0", n_issued, busy);
        end
        idle(L + 2);
        drive_cycle(4'b1001, 1'b1, 1'b0, gd, od);
        n_cmp++;
        if (od !== 4'b0001) begin
            n_bad++;
            $display("FAIL midflight_priority: got %b want 0001", od);
        end
        drive_cycle(4'b1000, 1'b1, 1'b0, gd, od);
        idle(L + 4);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        issue_en  = 1'b0;
        for (int i = 0; i < N; i++) begin
            nx[i] = W'(i + 1);
            ny[i] = W'(16 * (i + 1));
            req_X[i] = '0;
            req_Y[i] = '0;
        end
        test_reset();
        test_single();
        test_contention();
        test_round_robin();
        test_hold();
        test_wrap();
        test_reset_midflight();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d results outstanding want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mca_rr_scheduler.md
Name: mca_rr_scheduler

Overview:
- Shares one pipelined multi_cycle_adder (Fp-width, latency LATENCY) between N_REQ requesters using round-robin arbitration.
- Registers the granted operands and issues at most one addition per cycle.
- Tracks requester ID and valid bit through a tag pipeline aligned to the adder.
- Returns each sum with its requester ID. Sits between the Fp-arithmetic sequencers and the shared adder in the BN254 datapath.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- LATENCY, 2, multi_cycle_adder pipeline depth, passed to its latency parameter.
- ID_W, $clog2(N_REQ), requester ID width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  [N_REQ]  per-requester operation request.
- req_ready  out  [N_REQ]  per-requester grant; accept = req_valid[i] & req_ready[i].
- req_X  in  [N_REQ] x uint_fp_t  operand X per requester.
- req_Y  in  [N_REQ] x uint_fp_t  operand Y per requester.
- issue_en  in  1  when low, no grant is given (issue hold).
- res_valid  out  1  result strobe, one cycle per accepted request.
- res_id  out  ID_W  requester index of the current result.
- res_Z  out  uint_fp_t  (X+Y) mod 2^width(uint_fp_t).
- busy  out  1  any operation in the issue register or tag pipeline.
- n_issued  out  32  count of accepted requests, wraps at 2^32.

Behaviour:
- Reset (async, rst=1): all tag valids 0; res_valid=0; res_id=0; busy=0; n_issued=0; RR pointer last=N_REQ-1, so requester 0 has top priority. Operand and data registers are not reset. res_Z is don't-care while res_valid=0.
- Arbitration (combinational):
  - Search requesters last+1, last+2, ... mod N_REQ. The first i with req_valid[i]=1 is granted.
  - req_ready is one-hot or zero.
  - req_ready is all zero when issue_en=0 or rst=1.
  - req_ready[i] never depends on req_valid[i] of the granted requester itself beyond the selection.
- Pointer update: on an accepting edge, last <= granted index. With no grant, last is held.
- Issue stage, on the acceptance edge t:
  - X_r, Y_r <= granted operands.
  - v0 <= 1; id0 <= index.
  - n_issued <= n_issued+1.
  - With no acceptance: v0 <= 0 and X_r/Y_r are held.
- Adder: X_r/Y_r drive multi_cycle_adder (clk, X, Y, Z). The tag shift register v/id has LATENCY stages after v0/id0 and has no stall. The adder pipeline is free-running.
- Output: res_Z = adder Z. res_valid/res_id = last tag stage. Result appears with res_valid=1 in the cycle after edge t+1+LATENCY, i.e. LATENCY+1 cycles after acceptance.
- Throughput and ordering: one result per cycle max. Results return in acceptance order. No output backpressure; consumers must sample on res_valid.
- busy = v0 | OR of all tag valids.
- Fairness: a continuously requesting requester waits at most N_REQ-1 grants.
- Simultaneous events:
  - A request deasserted in the same cycle it would be granted is not accepted, and the pointer does not move.
  - issue_en falling blocks new grants only; in-flight operations complete.
- Reset mid-operation: all tag valids clear immediately, so in-flight results are dropped and no res_valid appears afterward. The pointer returns to last=N_REQ-1.
- Width: sum truncated to uint_fp_t width; carry-out discarded.

Test Plan:
- Single request: requester 2, X=5, Y=7, accepted at edge t -> res_valid=1, res_id=2, res_Z=12 exactly LATENCY+1 cycles later; n_issued=1; busy low afterward.
- Contention: all four req_valid held high from reset -> grants 0,1,2,3,0,... on consecutive cycles; results returned in the same ID order, one per cycle; no gaps.
- Round-robin: requesters 1 and 3 continuous, last grant 3 -> next grant 1, then 3, alternating; requester 0 asserts later -> granted within 2 grants.
- Hold: issue_en=0 for 5 cycles with requests pending -> req_ready=0, no new results after drain, busy falls after LATENCY+1 cycles; issue_en=1 resumes from saved pointer.
- Wrap-around: X=all-ones, Y=1 -> res_Z=0; X=Y=2^(width-1) -> res_Z=0; 10000 random pairs checked against a scoreboard by ID.
- Reset mid-flight: assert rst 1 cycle after two acceptances -> no res_valid during or after reset; n_issued=0; next request to requester 3 with requester 0 also pending -> requester 0 granted first.
